add_pipe_arb: RTL

ADD_PIPE_ARB -- requirements
Module: add_pipe_arb

---
 rtl/add_pipe_arb.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/add_pipe_arb.sv
// add_pipe_arb: two-requester round-robin front end for a shared pipelined adder,
// with per-requester credit-limited response FIFOs. Revision 1.0.
`default_nettype none

module add_pipe_arb_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count;
  logic             full;

  assign rd_ptr_next = rd_ptr + 1'b1;
  assign valid       = (count != '0);
  assign full        = (count == CW'(DEPTH));

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // head is a separate register so the output only changes on a pop or
  // when the first entry lands in an empty FIFO
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_next;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
      if (pop) begin
        if (count > CW'(1)) begin
          head <= mem[rd_ptr_next];
        end else if (push) begin
          head <= push_data;
        end
      end else if (!valid && push) begin
        head <= push_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    assert (reset || !(push && full));
  end
endmodule

module add_pipe_arb #(
  parameter int SIZE    = 32,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req0_valid,
  output logic                           req0_ready,
  input  logic [SIZE-1:0]                req0_a,
  input  logic [SIZE-1:0]                req0_b,
  input  logic                           req0_cin,
  input  logic                           req1_valid,
  output logic                           req1_ready,
  input  logic [SIZE-1:0]                req1_a,
  input  logic [SIZE-1:0]                req1_b,
  input  logic                           req1_cin,
  output logic                           add_issue,
  output logic [SIZE-1:0]                add_a,
  output logic [SIZE-1:0]                add_b,
  output logic                           add_cin,
  input  logic [SIZE-1:0]                add_sum,
  input  logic                           add_cout,
  output logic                           rsp0_valid,
  input  logic                           rsp0_ready,
  output logic [SIZE-1:0]                rsp0_sum,
  output logic                           rsp0_cout,
  output logic                           rsp1_valid,
  input  logic                           rsp1_ready,
  output logic [SIZE-1:0]                rsp1_sum,
  output logic                           rsp1_cout,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);

  logic [CW-1:0]      credit [2];
  logic [1:0]         eligible;
  logic [1:0]         grant;
  logic [1:0]         push;
  logic [1:0]         pop;
  logic [1:0]         rsp_valid;
  logic [SIZE:0]      rsp_head [2];
  logic               last_grant;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_id;

  assign eligible[0] = req0_valid && (credit[0] < CREDIT_MAX);
  assign eligible[1] = req1_valid && (credit[1] < CREDIT_MAX);

  // on a tie the requester that was not granted last wins
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (eligible == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = eligible;
      end
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign add_issue  = |grant;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (grant[0]) begin
      add_a   = req0_a;
      add_b   = req0_b;
      add_cin = req0_cin;
    end else if (grant[1]) begin
      add_a   = req1_a;
      add_b   = req1_b;
      add_cin = req1_cin;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= add_issue;
      tag_id[0]    <= grant[1];
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + IW'(tag_valid[i]);
    end
  end

  assign push[0] = tag_valid[LATENCY-1] && !tag_id[LATENCY-1];
  assign push[1] = tag_valid[LATENCY-1] &&  tag_id[LATENCY-1];
  assign pop     = rsp_valid & {rsp1_ready, rsp0_ready};

  // credit counts everything a requester owns: ops in the adder plus queued results
  always_ff @(posedge clock) begin
    if (reset) begin
      credit[0] <= '0;
      credit[1] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (grant[n] && !pop[n]) begin
          credit[n] <= credit[n] + 1'b1;
        end else if (!grant[n] && pop[n]) begin
          credit[n] <= credit[n] - 1'b1;
        end
      end
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_fifo
    add_pipe_arb_fifo #(
      .WIDTH (SIZE + 1),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push[n]),
      .push_data ({add_cout, add_sum}),
      .pop       (pop[n]),
      .valid     (rsp_valid[n]),
      .head      (rsp_head[n])
    );
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_sum   = rsp_head[0][SIZE-1:0];
  assign rsp0_cout  = rsp_head[0][SIZE];
  assign rsp1_sum   = rsp_head[1][SIZE-1:0];
  assign rsp1_cout  = rsp_head[1][SIZE];
endmodule

`default_nettype wire
